scaffold: RTL and testbench

SCAFFOLD -- requirements
Module: scaffold

---
 rtl/scaffold.sv | 248 ++++++++++++++++++++++++
 tb/tb_scaffold.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaffold.sv
// UDP packet scaffold: SPI slave to a microcontroller, mailbox and transmit buffers,
// a clk/4 SPI master to flash for port-1 packets, and a two-port transmit arbiter.
module scaffold #(
    parameter int BUF_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rx_ready,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_data,
    output logic [1:0]  tx_req,
    output logic [10:0] tx_len,
    input  logic        tx_ack,
    input  logic        tx_warn,
    output logic [7:0]  tx_data,
    input  logic        uc_clk,
    input  logic        uc_cs,
    input  logic        uc_mosi,
    output logic        uc_miso,
    output logic        uc_look_at_me,
    output logic        flash_clk,
    output logic        flash_cs,
    output logic        flash_mosi,
    input  logic        flash_miso,
    input  logic [15:0] status_in,
    output logic [8:0]  address_set,
    output logic        eth_inhibit
);
    localparam int DEPTH = 1 << BUF_AW;
    typedef logic [BUF_AW-1:0] ptr_t;
    typedef logic [BUF_AW:0]   cnt_t;
    localparam ptr_t LEN_MAX = '1;

    typedef enum logic [1:0] {TX_IDLE, TX_P0, TX_P1} tx_state_t;
    typedef enum logic {FL_IDLE, FL_RUN} fl_state_t;

    logic [7:0] uc_buf [DEPTH];
    logic [7:0] mbox   [DEPTH];
    logic [7:0] fl_buf [DEPTH];
    logic [7:0] rp_buf [DEPTH];

    logic [2:0] sck_s, cs_s;
    logic [1:0] mosi_s;
    logic [2:0] bit_cnt;
    cnt_t       byte_cnt;
    logic [6:0] shift_in, miso_sh;
    logic [7:0] cmd, next_byte, spi_byte;
    logic [15:0] status_q;
    logic       uc_accept;
    ptr_t       uc_len, mbox_len, mb_idx;
    logic       sck_rise, sck_fall, cs_fall, cs_rise, cs_act, byte_done;
    logic       uc_we, tx0_set, look_clr;

    logic [1:0] rx_sel;
    logic       rx_active, rx_keep, rx_strobe_d, rx_end, rx_store;
    ptr_t       rx_len;

    fl_state_t  fl_state;
    ptr_t       fl_len, fl_idx;
    logic [2:0] fl_bit;
    logic [1:0] fl_phase;
    logic [6:0] fl_sh;
    logic [7:0] fl_cur;
    logic       fl_start, fl_done, rp_we;

    tx_state_t  tx_state;
    logic       tx0_pend, tx1_pend, ack_seen;
    ptr_t       tx0_len, tx1_len, tx_cur_len, tx_rd;

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign cs_act    = ~cs_s[1];
    assign spi_byte  = {shift_in, mosi_s[1]};
    assign byte_done = cs_act && !cs_fall && sck_rise && bit_cnt == 3'd7;
    assign uc_we     = byte_done && byte_cnt != '0 && cmd == 8'h01 && uc_accept && uc_len != LEN_MAX;
    assign tx0_set   = cs_rise && cmd == 8'h01 && uc_accept && uc_len != '0;
    assign look_clr  = cs_rise && cmd == 8'h03;
    assign mb_idx    = ptr_t'(byte_cnt - cnt_t'(2));

    // Byte to shift out next; byte_cnt already counts the byte about to start.
    always_comb begin
        next_byte = 8'h00;
        if (cmd == 8'h04) begin
            if (byte_cnt == cnt_t'(1))      next_byte = status_q[15:8];
            else if (byte_cnt == cnt_t'(2)) next_byte = status_q[7:0];
        end else if (cmd == 8'h03) begin
            if (byte_cnt == cnt_t'(1))
                next_byte = 8'(mbox_len);
            else if (byte_cnt >= cnt_t'(2) && byte_cnt <= ({1'b0, mbox_len} + cnt_t'(1)))
                next_byte = mbox[mb_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s <= '0; cs_s <= '1; mosi_s <= '0;
            bit_cnt <= '0; byte_cnt <= '0; shift_in <= '0; miso_sh <= '0;
            cmd <= '0; status_q <= '0; uc_accept <= 1'b0; uc_len <= '0;
            uc_miso <= 1'b0; address_set <= '0; eth_inhibit <= 1'b1;
        end else begin
            sck_s  <= {sck_s[1:0], uc_clk};
            cs_s   <= {cs_s[1:0], uc_cs};
            mosi_s <= {mosi_s[0], uc_mosi};
            address_set[8] <= 1'b0;
            if (cs_fall) begin
                bit_cnt <= '0; byte_cnt <= '0; cmd <= '0;
                uc_miso <= 1'b0; miso_sh <= '0;
            end else if (cs_act) begin
                if (sck_rise) begin
                    shift_in <= {shift_in[5:0], mosi_s[1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + cnt_t'(1);
                    if (byte_cnt == '0) begin
                        cmd <= spi_byte;
                        if (spi_byte == 8'h02) eth_inhibit <= 1'b1;
                        if (spi_byte == 8'h04) status_q <= status_in;
                        if (spi_byte == 8'h01) begin
                            uc_accept <= !tx0_pend;
                            uc_len    <= '0;
                        end
                    end else if (cmd == 8'h02) begin
                        address_set <= {1'b1, spi_byte};
                    end
                end
                if (uc_we) uc_len <= uc_len + ptr_t'(1);
                if (sck_fall) begin
                    if (bit_cnt == 3'd0) {uc_miso, miso_sh} <= next_byte;
                    else                 {uc_miso, miso_sh} <= {miso_sh, 1'b0};
                end
            end
            if (cs_rise && cmd == 8'h02 && byte_cnt >= cnt_t'(2)) eth_inhibit <= 1'b0;
        end
    end

    // Receive path: the destination decision is frozen when rx_ready pulses.
    assign rx_end   = rx_active && rx_ready == 2'b00 && rx_strobe_d && !rx_strobe;
    assign rx_store = rx_active && rx_ready == 2'b00 && rx_strobe && rx_keep && rx_len != LEN_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sel <= '0; rx_active <= 1'b0; rx_keep <= 1'b0; rx_strobe_d <= 1'b0;
            rx_len <= '0; mbox_len <= '0; uc_look_at_me <= 1'b0;
        end else begin
            rx_strobe_d <= rx_strobe;
            if (look_clr) uc_look_at_me <= 1'b0;
            if (rx_ready != 2'b00) begin
                rx_active <= 1'b1;
                rx_len    <= '0;
                rx_sel    <= rx_ready[0] ? 2'b01 : 2'b10;
                rx_keep   <= rx_ready[0] ? !uc_look_at_me : (fl_state == FL_IDLE && !tx1_pend);
            end else if (rx_active) begin
                if (rx_store) rx_len <= rx_len + ptr_t'(1);
                if (rx_end) begin
                    rx_active <= 1'b0;
                    if (rx_keep && rx_sel[0] && rx_len != '0) begin
                        mbox_len      <= rx_len;
                        uc_look_at_me <= 1'b1;
                    end
                end
            end
        end
    end

    // Flash master: four clk cycles per bit, phases 0-1 low, 2-3 high.
    assign fl_cur   = fl_buf[fl_idx];
    assign fl_start = rx_end && rx_keep && rx_sel[1] && rx_len != '0;
    assign fl_done  = fl_state == FL_RUN && fl_phase == 2'd3 && fl_bit == 3'd7
                      && (fl_idx + ptr_t'(1)) == fl_len;
    assign rp_we    = fl_state == FL_RUN && fl_phase == 2'd2 && fl_bit == 3'd7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_state <= FL_IDLE; fl_len <= '0; fl_idx <= '0; fl_bit <= '0;
            fl_phase <= '0; fl_sh <= '0;
            flash_cs <= 1'b1; flash_clk <= 1'b0; flash_mosi <= 1'b0;
        end else begin
            case (fl_state)
                FL_IDLE: if (fl_start) begin
                    fl_state <= FL_RUN; flash_cs <= 1'b0; fl_len <= rx_len;
                    fl_idx <= '0; fl_bit <= '0; fl_phase <= '0;
                end
                default: begin
                    fl_phase <= fl_phase + 2'd1;
                    case (fl_phase)
                        2'd0: flash_mosi <= fl_cur[3'd7 - fl_bit];
                        2'd1: flash_clk  <= 1'b1;
                        2'd2: fl_sh      <= {fl_sh[5:0], flash_miso};
                        default: begin
                            flash_clk <= 1'b0;
                            fl_bit    <= fl_bit + 3'd1;
                            if (fl_bit == 3'd7) fl_idx <= fl_idx + ptr_t'(1);
                            if (fl_done) begin
                                fl_state <= FL_IDLE; flash_cs <= 1'b1; flash_mosi <= 1'b0;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (uc_we) uc_buf[uc_len] <= spi_byte;
        if (rx_store && rx_sel[0]) mbox[rx_len] <= rx_data;
        if (rx_store && rx_sel[1]) fl_buf[rx_len] <= rx_data;
        if (rp_we) rp_buf[fl_idx] <= {fl_sh, flash_miso};
    end

    // Transmit arbiter; port 0 is examined first so it wins ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE; tx0_pend <= 1'b0; tx1_pend <= 1'b0; ack_seen <= 1'b0;
            tx0_len <= '0; tx1_len <= '0; tx_cur_len <= '0; tx_rd <= '0;
            tx_req <= '0; tx_len <= '0; tx_data <= '0;
        end else begin
            if (tx0_set) begin tx0_pend <= 1'b1; tx0_len <= uc_len; end
            if (fl_done) begin tx1_pend <= 1'b1; tx1_len <= fl_len; end
            case (tx_state)
                TX_IDLE: begin
                    tx_rd <= '0; ack_seen <= 1'b0;
                    if (tx0_pend) begin
                        tx_state <= TX_P0; tx_req <= 2'b01;
                        tx_len <= 11'(tx0_len); tx_cur_len <= tx0_len;
                    end else if (tx1_pend) begin
                        tx_state <= TX_P1; tx_req <= 2'b10;
                        tx_len <= 11'(tx1_len); tx_cur_len <= tx1_len;
                    end
                end
                default: begin
                    if (tx_ack) ack_seen <= 1'b1;
                    if (tx_warn) begin
                        tx_data <= (tx_state == TX_P0) ? uc_buf[tx_rd] : rp_buf[tx_rd];
                        tx_rd   <= tx_rd + ptr_t'(1);
                    end
                    if ((tx_warn && (tx_rd + ptr_t'(1)) == tx_cur_len) || (ack_seen && !tx_ack)) begin
                        tx_state <= TX_IDLE; tx_req <= 2'b00;
                        if (tx_state == TX_P0) tx0_pend <= 1'b0;
                        else                   tx1_pend <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scaffold.sv
// Bench for scaffold: SPI master driver, packet source, flash slave model and
// transmitter driver, all checked against expected-byte queues.
module tb_scaffold;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rx_ready = '0;
    logic        rx_strobe = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [1:0]  tx_req;
    logic [10:0] tx_len;
    logic        tx_ack = 1'b0;
    logic        tx_warn = 1'b0;
    logic [7:0]  tx_data;
    logic        uc_clk = 1'b0, uc_cs = 1'b1, uc_mosi = 1'b0;
    logic        uc_miso, uc_look_at_me;
    logic        flash_clk, flash_cs, flash_mosi;
    logic        flash_miso = 1'b0;
    logic [15:0] status_in = '0;
    logic [8:0]  address_set;
    logic        eth_inhibit;

    scaffold #(.BUF_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_strobe(rx_strobe),
        .rx_data(rx_data), .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack),
        .tx_warn(tx_warn), .tx_data(tx_data), .uc_clk(uc_clk), .uc_cs(uc_cs),
        .uc_mosi(uc_mosi), .uc_miso(uc_miso), .uc_look_at_me(uc_look_at_me),
        .flash_clk(flash_clk), .flash_cs(flash_cs), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso), .status_in(status_in), .address_set(address_set),
        .eth_inhibit(eth_inhibit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] miso_q[$], addr_q[$], tx_q[$], flash_q[$];
    logic [7:0] rx_buf[0:299];
    logic [7:0] rep[0:11];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // which: 0 miso, 1 address_set, 2 tx, 3 flash
    task automatic push(input int which, input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = v[8*(n-1-k) +: 8];
            case (which)
                0: miso_q.push_back(b);
                1: addr_q.push_back(b);
                2: tx_q.push_back(b);
                default: flash_q.push_back(b);
            endcase
        end
    endtask

    task automatic spi_begin();
        uc_cs = 1'b0;
        wait_clks(8);
    endtask

    task automatic spi_end();
        wait_clks(8);
        uc_cs = 1'b1;
        wait_clks(12);
    endtask

    task automatic spi_bytes(input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b, r, e;
            b = v[8*(n-1-k) +: 8];
            for (int i = 7; i >= 0; i--) begin
                uc_mosi = b[i];
                wait_clks(8);
                uc_clk = 1'b1;
                r[i] = uc_miso;
                wait_clks(8);
                uc_clk = 1'b0;
            end
            if (miso_q.size() != 0) begin
                e = miso_q.pop_front();
                check("uc_miso", 16'(r), 16'(e));
            end
        end
    endtask

    task automatic spi_xfer(input logic [127:0] v, input int n);
        spi_begin();
        spi_bytes(v, n);
        spi_end();
    endtask

    task automatic load_rx(input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) rx_buf[k] = v[8*(n-1-k) +: 8];
    endtask

    task automatic rx_packet(input logic [1:0] port, input int n);
        @(negedge clk) rx_ready = port;
        @(negedge clk) rx_ready = 2'b00;
        for (int i = 0; i < n; i++) begin
            rx_strobe = 1'b1;
            rx_data = rx_buf[i];
            @(negedge clk);
        end
        rx_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_req(input logic [1:0] want, input int budget);
        int k = 0;
        while (tx_req !== want && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_req_raise", 16'(tx_req), 16'(want));
    endtask

    task automatic tx_drain(input int n, input logic [1:0] port);
        logic [7:0] e;
        tx_ack = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                check("tx_data", 16'(tx_data), 16'(e));
            end
            if (i == n - 1) check("tx_req_held", 16'(tx_req), 16'(port));
            if (i == n) check("tx_req_drop", 16'(tx_req), 16'h0);
            tx_warn = (i < n);
        end
        tx_warn = 1'b0;
        tx_ack = 1'b0;
    endtask

    // address_set strobes and a mode-0 flash slave, sampled mid-cycle
    int fl_bits = 0, fl_txns = 0, fl_hi = 0, fl_lo = 0;
    logic [7:0] fl_sh = '0;
    logic fcs_q = 1'b1, fclk_q = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e, r;
        if (address_set[8]) begin
            if (addr_q.size() != 0) begin
                e = addr_q.pop_front();
                check("address_set", 16'(address_set), {7'h0, 1'b1, e});
            end else begin
                check("address_set_extra", 16'(address_set), 16'h0);
            end
        end
        if (rst_n) begin
            if (fcs_q && !flash_cs) begin
                fl_txns++;
                fl_bits = 0;
                r = rep[0];
                flash_miso = r[7];
            end
            if (!flash_cs) begin
                if (flash_clk) fl_hi++;
                else fl_lo++;
                if (flash_clk && !fclk_q) begin
                    fl_sh = {fl_sh[6:0], flash_mosi};
                    fl_bits++;
                    if (fl_bits % 8 == 0) begin
                        e = (flash_q.size() != 0) ? flash_q.pop_front() : 8'h00;
                        check("flash_mosi", 16'(fl_sh), 16'(e));
                    end
                end
                if (!flash_clk && fclk_q && fl_bits < 96) begin
                    r = rep[fl_bits / 8];
                    flash_miso = r[3'(7 - fl_bits % 8)];
                end
            end
        end
        fcs_q = flash_cs;
        fclk_q = flash_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++) rep[i] = 8'(8'h71 + i);
        wait_clks(5);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_req", 16'(tx_req), 16'h0);
        check("rst_tx_len", 16'(tx_len), 16'h0);
        check("rst_tx_data", 16'(tx_data), 16'h0);
        check("rst_uc_miso", 16'(uc_miso), 16'h0);
        check("rst_look", 16'(uc_look_at_me), 16'h0);
        check("rst_flash_cs", 16'(flash_cs), 16'h1);
        check("rst_flash_clk", 16'(flash_clk), 16'h0);
        check("rst_flash_mosi", 16'(flash_mosi), 16'h0);
        check("rst_address_set", 16'(address_set), 16'h0);
        check("rst_eth_inhibit", 16'(eth_inhibit), 16'h1);

        // configuration bytes
        push(1, 128'h23456789abcdef, 7);
        push(0, 128'h0, 8);
        spi_begin();
        spi_bytes(128'h0223456789abcdef, 8);
        check("eth_inhibit_held", 16'(eth_inhibit), 16'h1);
        spi_end();
        check("eth_inhibit_clear", 16'(eth_inhibit), 16'h0);
        check("addr_q_left", 16'(addr_q.size()), 16'h0);

        // micro-originated transmit on port 0
        push(0, 128'h0, 8);
        push(2, 128'h0e456789abcdef, 7);
        spi_xfer(128'h010e456789abcdef, 8);
        wait_req(2'b01, 50);
        check("tx_len_p0", 16'(tx_len), 16'd7);
        tx_drain(7, 2'b01);

        // status readback
        status_in = 16'h5a5a;
        push(0, 128'h005a5a0000, 5);
        spi_xfer(128'h0422222222, 5);

        // unknown command
        push(0, 128'h0, 3);
        spi_xfer(128'h55a5c3, 3);
        check("unknown_tx_req", 16'(tx_req), 16'h0);
        check("unknown_eth", 16'(eth_inhibit), 16'h0);

        // port-0 mailbox; the second packet arrives while pending and is dropped
        load_rx(128'h042122452384a44525334e06, 12);
        rx_packet(2'b01, 12);
        check("look_set", 16'(uc_look_at_me), 16'h1);
        load_rx(128'hdeadbeef, 4);
        rx_packet(2'b01, 4);
        push(0, 128'h000c0421224523_84a4, 9);
        spi_xfer(128'h03_0000000000000000, 9);
        check("look_clear", 16'(uc_look_at_me), 16'h0);

        // oversize port-0 packet is truncated
        for (int i = 0; i < 300; i++) rx_buf[i] = 8'(i + 1);
        rx_packet(2'b01, 300);
        check("look_set_long", 16'(uc_look_at_me), 16'h1);
        push(0, 128'h00ff01, 3);
        spi_xfer(128'h030000, 3);

        // port-1 flash round trip; the second packet arrives while busy and is dropped
        push(3, 128'h450145024503450445054506, 12);
        push(2, 128'h7172737475767778797a7b7c, 12);
        load_rx(128'h450145024503450445054506, 12);
        rx_packet(2'b10, 12);
        load_rx(128'haabbccdd, 4);
        rx_packet(2'b10, 4);
        wait_req(2'b10, 1000);
        check("tx_len_p1", 16'(tx_len), 16'd12);
        tx_drain(12, 2'b10);
        check("flash_bits", 16'(fl_bits), 16'd96);
        check("flash_hi", 16'(fl_hi), 16'd192);
        check("flash_lo", 16'(fl_lo), 16'd192);
        check("flash_q_left", 16'(flash_q.size()), 16'h0);
        check("tx_q_left", 16'(tx_q.size()), 16'h0);
        wait_clks(600);
        check("flash_txns", 16'(fl_txns), 16'd1);
        check("tx_req_idle", 16'(tx_req), 16'h0);
        check("flash_cs_idle", 16'(flash_cs), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
